// File: rtl/draw_arbiter.sv
// Purpose: round-robin arbiter sharing one VGA pixel-write port between three
//   rectangle requesters; walks the granted rectangle one pixel per clock.
// Latency: req sampled at IDLE edge k -> first pixel at edge k+1; done one edge
//   after the last pixel. Backpressure: none downstream; requesters wait on req.
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   req[2:0]                     level-sensitive request per requester
//   req_x/_y/_w/_h/_colour       packed descriptors, requester i at slot i
//   grant[2:0]                   one-hot, high while that rectangle is drawn
//   done[2:0]                    one-cycle pulse when a rectangle completes
//   busy                         high whenever the FSM is not idle
//   plot, vga_x, vga_y, vga_colour   VGA adapter write port
module draw_arbiter #(
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int CW       = 3,
  parameter int SW       = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        req,
  input  logic [3*XW-1:0]   req_x,
  input  logic [3*YW-1:0]   req_y,
  input  logic [3*SW-1:0]   req_w,
  input  logic [3*SW-1:0]   req_h,
  input  logic [3*CW-1:0]   req_colour,
  output logic [2:0]        grant,
  output logic [2:0]        done,
  output logic              busy,
  output logic              plot,
  output logic [XW-1:0]     vga_x,
  output logic [YW-1:0]     vga_y,
  output logic [CW-1:0]     vga_colour
);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_FIN} state_t;

  // Screen limits widened by one bit so the comparison against the
  // untruncated sum also catches coordinate overflow.
  localparam logic [XW:0] LP_SCR_W = (XW+1)'(SCREEN_W);
  localparam logic [YW:0] LP_SCR_H = (YW+1)'(SCREEN_H);

  state_t        r_state;
  logic [1:0]    r_last;
  logic [1:0]    r_idx;
  logic [XW-1:0] r_bx;
  logic [YW-1:0] r_by;
  logic [SW-1:0] r_bw;
  logic [SW-1:0] r_bh;
  logic [CW-1:0] r_bc;
  logic [SW-1:0] r_cx;
  logic [SW-1:0] r_cy;

  logic [1:0]    w_c1;
  logic [1:0]    w_c2;
  logic [1:0]    w_c3;
  logic [1:0]    w_pick;
  logic [XW:0]   w_sx;
  logic [YW:0]   w_sy;
  logic          w_clip;
  logic          w_last_px;

  // Search order starts just after the last served requester, so the one
  // just served is considered last.
  always_comb begin
    w_c1 = 2'd0;
    w_c2 = 2'd1;
    w_c3 = 2'd2;
    case (r_last)
      2'd0: begin w_c1 = 2'd1; w_c2 = 2'd2; w_c3 = 2'd0; end
      2'd1: begin w_c1 = 2'd2; w_c2 = 2'd0; w_c3 = 2'd1; end
      default: begin w_c1 = 2'd0; w_c2 = 2'd1; w_c3 = 2'd2; end
    endcase
    w_pick = w_c3;
    if (req[w_c1])      w_pick = w_c1;
    else if (req[w_c2]) w_pick = w_c2;
  end

  always_comb begin
    w_sx      = {1'b0, r_bx} + {{(XW+1-SW){1'b0}}, r_cx};
    w_sy      = {1'b0, r_by} + {{(YW+1-SW){1'b0}}, r_cy};
    w_clip    = (w_sx >= LP_SCR_W) || (w_sy >= LP_SCR_H);
    w_last_px = (r_cx == r_bw) && (r_cy == r_bh);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_last     <= 2'd2;
      r_idx      <= 2'd0;
      r_bx       <= '0;
      r_by       <= '0;
      r_bw       <= '0;
      r_bh       <= '0;
      r_bc       <= '0;
      r_cx       <= '0;
      r_cy       <= '0;
      grant      <= '0;
      done       <= '0;
      busy       <= 1'b0;
      plot       <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= '0;
          plot <= 1'b0;
          if (|req) begin
            r_idx   <= w_pick;
            r_bx    <= req_x[w_pick*XW +: XW];
            r_by    <= req_y[w_pick*YW +: YW];
            r_bw    <= req_w[w_pick*SW +: SW];
            r_bh    <= req_h[w_pick*SW +: SW];
            r_bc    <= req_colour[w_pick*CW +: CW];
            r_cx    <= '0;
            r_cy    <= '0;
            grant   <= 3'b001 << w_pick;
            busy    <= 1'b1;
            r_state <= S_DRAW;
          end
        end
        S_DRAW: begin
          // Clipped pixels still move the coordinates, only the write is masked.
          plot       <= !w_clip;
          vga_x      <= w_sx[XW-1:0];
          vga_y      <= w_sy[YW-1:0];
          vga_colour <= r_bc;
          if (r_cx < r_bw) begin
            r_cx <= r_cx + SW'(1);
          end else begin
            r_cx <= '0;
            r_cy <= r_cy + SW'(1);
          end
          if (w_last_px) r_state <= S_FIN;
        end
        S_FIN: begin
          plot    <= 1'b0;
          grant   <= '0;
          done    <= grant;
          busy    <= 1'b0;
          r_last  <= r_idx;
          r_cx    <= '0;
          r_cy    <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_arbiter.sv
module tb_draw_arbiter;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;
  localparam int SW = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [2:0]      req;
  logic [3*XW-1:0] req_x;
  logic [3*YW-1:0] req_y;
  logic [3*SW-1:0] req_w;
  logic [3*SW-1:0] req_h;
  logic [3*CW-1:0] req_colour;
  logic [2:0]      grant;
  logic [2:0]      done;
  logic            busy;
  logic            plot;
  logic [XW-1:0]   vga_x;
  logic [YW-1:0]   vga_y;
  logic [CW-1:0]   vga_colour;

  int checks   = 0;
  int failures = 0;

  draw_arbiter #(.XW(XW), .YW(YW), .CW(CW), .SW(SW), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clk(clk), .reset_n(reset_n), .req(req),
    .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h), .req_colour(req_colour),
    .grant(grant), .done(done), .busy(busy), .plot(plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int idx; int x; int y; int w; int h; int c; int chg;
    int exp_cycles; int exp_plots; int exp_lx; int exp_ly;
  } job_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic set_desc(input int idx, input int x, input int y, input int w, input int h, input int c);
    req_x[idx*XW +: XW]      = x[XW-1:0];
    req_y[idx*YW +: YW]      = y[YW-1:0];
    req_w[idx*SW +: SW]      = w[SW-1:0];
    req_h[idx*SW +: SW]      = h[SW-1:0];
    req_colour[idx*CW +: CW] = c[CW-1:0];
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_done"},  32'(done),  32'd0);
    check({tag, "_busy"},  32'(busy),  32'd0);
    check({tag, "_plot"},  32'(plot),  32'd0);
    check({tag, "_xyc"},   32'({vga_colour, vga_y, vga_x}), 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = 3'b000;
    tick();
    tick();
    check_all_zero("reset");
    reset_n = 1'b1;
  endtask

  // Drives one rectangle from a single requester and checks every emitted pixel.
  task automatic run_job(input job_t j);
    int n, plots, lx, ly, cx, cy, ex, ey;
    bit seen, ep;
    logic [18:0] exp_px;
    logic [2:0]  g;
    g = 3'b001 << j.idx;
    set_desc(j.idx, j.x, j.y, j.w, j.h, j.c);
    req = g;
    tick();
    check("sel_grant", 32'(grant), 32'(g));
    check("sel_busy",  32'(busy),  32'd1);
    check("sel_plot",  32'(plot),  32'd0);
    if (j.chg == 0) req = 3'b000;
    n = 0; plots = 0; lx = 0; ly = 0; seen = 0;
    for (int t = 0; t < 300; t++) begin
      tick();
      if (done != 3'b000) begin
        seen = 1;
        break;
      end
      cx = n % (j.w + 1);
      cy = n / (j.w + 1);
      ex = (j.x + cx) % 256;
      ey = (j.y + cy) % 128;
      ep = ((j.x + cx) < 160) && ((j.y + cy) < 120);
      exp_px = {ep, j.c[2:0], ey[6:0], ex[7:0]};
      check("pixel", 32'({plot, vga_colour, vga_y, vga_x}), 32'(exp_px));
      check("draw_grant", 32'(grant), 32'(g));
      plots += int'(plot);
      lx = int'(vga_x);
      ly = int'(vga_y);
      n++;
      if (j.chg != 0 && n == 3) begin
        set_desc(j.idx, j.x + 37, j.y, j.w, j.h, j.c);
        req = 3'b000;
      end
    end
    check("done_seen",  32'(seen),  32'd1);
    check("done_vec",   32'(done),  32'(g));
    check("fin_grant",  32'(grant), 32'd0);
    check("fin_plot",   32'(plot),  32'd0);
    check("fin_busy",   32'(busy),  32'd0);
    check("draw_cycles", 32'(n),     32'(j.exp_cycles));
    check("plot_count",  32'(plots), 32'(j.exp_plots));
    check("last_x",      32'(lx),    32'(j.exp_lx));
    check("last_y",      32'(ly),    32'(j.exp_ly));
    tick();
    check("done_pulse_end", 32'(done), 32'd0);
  endtask

  job_t jobs[6];
  logic [2:0] eg, ed;

  initial begin
    reset_n = 1'b0; req = '0;
    req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_colour = '0;

    //         idx  x    y    w   h   c  chg cyc  plots lx   ly
    jobs[0] = '{0,  10,  20,  1,  1,  5, 0,  4,   4,    11,  21};   // 2x2 basic
    jobs[1] = '{1,  158, 118, 3,  3,  2, 0,  16,  4,    161, 121};  // edge clip
    jobs[2] = '{2,  0,   0,   15, 15, 7, 0,  256, 256,  15,  15};   // max size
    jobs[3] = '{0,  250, 100, 7,  0,  3, 0,  8,   0,    1,   100};  // x overflow
    jobs[4] = '{1,  5,   126, 0,  2,  1, 0,  3,   0,    5,   0};    // y overflow
    jobs[5] = '{2,  40,  30,  3,  3,  4, 1,  16,  16,   43,  33};   // change x + drop req mid-draw

    do_reset();
    foreach (jobs[i]) run_job(jobs[i]);

    // Round-robin with all requests held: 3 cycles per 1x1 rectangle.
    do_reset();
    for (int i = 0; i < 3; i++) set_desc(i, 10*i, 10*i, 0, 0, i + 1);
    req = 3'b111;
    for (int i = 1; i <= 18; i++) begin
      tick();
      eg = ((i - 1) % 3 < 2) ? (3'b001 << (((i - 1) / 3) % 3)) : 3'b000;
      ed = ((i - 1) % 3 == 2) ? (3'b001 << (((i - 1) / 3) % 3)) : 3'b000;
      check("rr_grant", 32'(grant), 32'(eg));
      check("rr_done",  32'(done),  32'(ed));
      check("rr_plot",  32'(plot),  32'(((i - 1) % 3) == 1));
      if (i == 18) req = 3'b000;
    end
    tick();
    check("rr_idle_grant", 32'(grant), 32'd0);

    // Reset during pixel 5 of a 4x4 rectangle.
    set_desc(0, 20, 20, 3, 3, 1);
    req = 3'b001;
    tick();
    check("mr_grant", 32'(grant), 32'b001);
    req = 3'b000;
    for (int i = 0; i < 5; i++) tick();
    check("mr_pixel5", 32'({plot, vga_y, vga_x}), 32'({1'b1, 7'd21, 8'd20}));
    reset_n = 1'b0;
    tick();
    check_all_zero("mr_reset");
    reset_n = 1'b1;
    set_desc(1, 1, 1, 0, 0, 2);
    set_desc(2, 2, 2, 0, 0, 3);
    req = 3'b110;
    tick();
    check("mr_grant1", 32'(grant), 32'b010);
    check("mr_no_done", 32'(done), 32'd0);
    tick();
    check("mr_px1", 32'({plot, vga_colour, vga_y, vga_x}), 32'({1'b1, 3'd2, 7'd1, 8'd1}));
    tick();
    check("mr_done1", 32'(done), 32'b010);
    tick();
    check("mr_grant2", 32'(grant), 32'b100);
    req = 3'b000;
    tick();
    check("mr_px2", 32'({plot, vga_colour, vga_y, vga_x}), 32'({1'b1, 3'd3, 7'd2, 8'd2}));
    tick();
    check("mr_done2", 32'(done), 32'b100);
    tick();
    check("mr_final_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
